x_calculate_multi: RTL and testbench

X_CALCULATE_MULTI -- requirements
Module: x_calculate_multi

---
 rtl/x_calculate_multi.sv | 194 +++++++++++++++++++
 tb/tb_x_calculate_multi.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_calculate_multi.sv
// x_calculate_multi: streams a complex H matrix row-major and reports
// saturated squared column norms for one column or for every column.
module x_calculate_multi #(
    parameter int Q    = 16,
    parameter int N    = 32,
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int QIW  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_new_q,
    input  logic [QIW-1:0]      q_index,
    input  logic                mode_all,
    input  logic                H_in_valid,
    output logic                H_in_ready,
    input  logic signed [N-1:0] H_in_r,
    input  logic signed [N-1:0] H_in_i,
    output logic [N-1:0]        Dh_out,
    output logic [QIW-1:0]      Dh_col,
    output logic                Dh_result_valid,
    output logic                Dh_sat,
    output logic                q_calc_done,
    output logic                q_err
);

    localparam int AW = N + $clog2(ROWS) + 1;
    localparam int KW = $clog2(ROWS * COLS) + 1;
    localparam int PW = 2 * N;

    localparam logic [KW-1:0]  LAST_K = KW'(ROWS * COLS - 1);
    localparam logic [QIW-1:0] LAST_C = QIW'(COLS - 1);
    localparam logic [QIW-1:0] COLS_Q = QIW'(COLS);

    localparam logic signed [AW-1:0] OUT_MAX =
        {{(AW - N + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [PW:0] ACC_MAX =
        {{(PW - AW + 2){1'b0}}, {(AW - 1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [KW-1:0]        k_cnt;
    logic [QIW-1:0]       col;
    logic [QIW-1:0]       oc;
    logic [QIW-1:0]       q_lat;
    logic                 mode_lat;
    logic                 q_err_q;
    logic signed [AW-1:0] acc [COLS];

    logic                 start_ok;
    logic                 start_bad;
    logic                 can_start;
    logic                 beat;
    logic                 out_last;
    logic signed [PW-1:0] pr;
    logic signed [PW-1:0] pi;
    logic signed [PW-1:0] term;
    logic signed [AW-1:0] acc_cur;
    logic signed [PW:0]   acc_sum;
    logic signed [AW-1:0] acc_new;
    logic [QIW-1:0]       out_col;
    logic signed [AW-1:0] sel_acc;

    assign can_start = (state == IDLE) || (state == LOAD);
    assign start_ok  = start_new_q && (mode_all || (q_index < COLS_Q));
    assign start_bad = start_new_q && !start_ok;
    assign beat      = (state == LOAD) && H_in_valid && !start_new_q;
    assign out_last  = !mode_lat || (oc == LAST_C);
    assign out_col   = mode_lat ? oc : q_lat;

    // Per-beat energy term and saturating column accumulate
    always_comb begin
        pr      = H_in_r * H_in_r;
        pi      = H_in_i * H_in_i;
        term    = (pr >>> Q) + (pi >>> Q);
        acc_cur = '0;
        sel_acc = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col == QIW'(c))
                acc_cur = acc[c];
            if (out_col == QIW'(c))
                sel_acc = acc[c];
        end
        // Terms are never negative, so only the top needs clamping;
        // a pinned accumulator still clamps to the same output value.
        acc_sum = {{(PW + 1 - AW){acc_cur[AW-1]}}, acc_cur}
                + {term[PW-1], term};
        if (acc_sum > ACC_MAX)
            acc_new = ACC_MAX[AW-1:0];
        else
            acc_new = acc_sum[AW-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_ok)
                    state_nxt = LOAD;
            end
            LOAD: begin
                if (start_new_q)
                    state_nxt = start_ok ? LOAD : IDLE;
                else if (H_in_valid && (k_cnt == LAST_K))
                    state_nxt = OUT;
            end
            OUT: begin
                if (out_last)
                    state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: request latch, element counters, accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            k_cnt    <= '0;
            col      <= '0;
            oc       <= '0;
            q_lat    <= '0;
            mode_lat <= 1'b0;
            q_err_q  <= 1'b0;
            for (int c = 0; c < COLS; c++)
                acc[c] <= '0;
        end else begin
            q_err_q <= can_start && start_bad;
            if (can_start && start_ok) begin
                q_lat    <= q_index;
                mode_lat <= mode_all;
                k_cnt    <= '0;
                col      <= '0;
                oc       <= '0;
                for (int c = 0; c < COLS; c++)
                    acc[c] <= '0;
            end else if (beat) begin
                k_cnt <= k_cnt + 1'b1;
                col   <= (col == LAST_C) ? '0 : col + 1'b1;
                for (int c = 0; c < COLS; c++)
                    if (col == QIW'(c))
                        acc[c] <= acc_new;
            end
            if (state == OUT)
                oc <= oc + 1'b1;
        end
    end

    // Outputs decoded from state, forced quiet while in reset
    always_comb begin
        H_in_ready      = 1'b0;
        Dh_result_valid = 1'b0;
        Dh_out          = '0;
        Dh_col          = '0;
        Dh_sat          = 1'b0;
        q_calc_done     = 1'b0;
        q_err           = 1'b0;
        if (!rst) begin
            H_in_ready  = (state == LOAD);
            q_calc_done = (state == DONE);
            q_err       = q_err_q;
            if (state == OUT) begin
                Dh_result_valid = 1'b1;
                Dh_col          = out_col;
                if (sel_acc > OUT_MAX) begin
                    Dh_out = OUT_MAX[N-1:0];
                    Dh_sat = 1'b1;
                end else if (sel_acc < 0) begin
                    Dh_out = '0;
                    Dh_sat = 1'b1;
                end else begin
                    Dh_out = sel_acc[N-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_x_calculate_multi.sv
// Randomized bench for x_calculate_multi: a column-sum reference model
// and an output monitor feed one checking task.
module tb_x_calculate_multi;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_new_q = 1'b0;
    logic [3:0]         q_index = '0;
    logic               mode_all = 1'b0;
    logic               H_in_valid = 1'b0;
    logic               H_in_ready;
    logic signed [31:0] H_in_r = '0;
    logic signed [31:0] H_in_i = '0;
    logic [31:0]        Dh_out;
    logic [3:0]         Dh_col;
    logic               Dh_result_valid;
    logic               Dh_sat;
    logic               q_calc_done;
    logic               q_err;

    x_calculate_multi dut (
        .clk(clk), .rst(rst), .start_new_q(start_new_q),
        .q_index(q_index), .mode_all(mode_all),
        .H_in_valid(H_in_valid), .H_in_ready(H_in_ready),
        .H_in_r(H_in_r), .H_in_i(H_in_i),
        .Dh_out(Dh_out), .Dh_col(Dh_col),
        .Dh_result_valid(Dh_result_valid), .Dh_sat(Dh_sat),
        .q_calc_done(q_calc_done), .q_err(q_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    logic signed [31:0] mr [16];
    logic signed [31:0] mi [16];

    int   res_col [$];
    logic [31:0] res_out [$];
    int   res_sat [$];
    int   res_cyc [$];
    int   done_n, done_cyc, err_n, ready_n, idle_bad, last_beat;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor sampled on the falling edge
    always @(negedge clk) begin
        if (Dh_result_valid) begin
            res_col.push_back(int'(Dh_col));
            res_out.push_back(Dh_out);
            res_sat.push_back(int'(Dh_sat));
            res_cyc.push_back(cyc);
        end else if (Dh_out != 0 || Dh_col != 0 || Dh_sat) begin
            idle_bad++;
        end
        if (q_calc_done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (q_err) err_n++;
        if (H_in_ready) ready_n++;
        if (H_in_valid && H_in_ready) last_beat = cyc;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        res_col.delete();
        res_out.delete();
        res_sat.delete();
        res_cyc.delete();
        done_n = 0; done_cyc = 0; err_n = 0;
        ready_n = 0; idle_bad = 0; last_beat = -100;
    endtask

    // Reference: true column energy sum, then clamp to the output range
    task automatic model(input int c, output logic [31:0] v,
                         output int s);
        longint sum, a, b;
        sum = 0;
        for (int r = 0; r < 4; r++) begin
            a = longint'(mr[r*4+c]);
            b = longint'(mi[r*4+c]);
            sum += ((a * a) >>> 16) + ((b * b) >>> 16);
        end
        if (sum > 64'sh7FFFFFFF) begin
            v = 32'h7FFFFFFF; s = 1;
        end else begin
            v = sum[31:0]; s = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit all, input logic [3:0] q);
        start_new_q = 1'b1;
        mode_all = all;
        q_index = q;
        step();
        start_new_q = 1'b0;
    endtask

    task automatic do_beat(input int k, input int gapmax);
        int t;
        repeat ($urandom_range(0, gapmax)) begin
            H_in_r = $urandom;
            H_in_i = $urandom;
            step();
        end
        t = 0;
        while (!H_in_ready && t < 20) begin
            step();
            t++;
        end
        if (!H_in_ready) chk("ready_wait", 0, 1);
        H_in_valid = 1'b1;
        H_in_r = mr[k];
        H_in_i = mi[k];
        step();
        H_in_valid = 1'b0;
    endtask

    task automatic finish_check(input bit all, input logic [3:0] q);
        int t, nexp;
        logic [31:0] v;
        int s, c;
        t = 0;
        while (done_n == 0 && t < 60) begin
            step();
            t++;
        end
        step();
        nexp = all ? 4 : 1;
        chk("n_results", res_col.size(), nexp);
        chk("n_done", done_n, 1);
        for (int i = 0; i < nexp && i < res_col.size(); i++) begin
            c = all ? i : int'(q);
            model(c, v, s);
            chk("col", res_col[i], c);
            chk("norm", res_out[i], v);
            chk("sat", res_sat[i], s);
            chk("res_cyc", res_cyc[i], last_beat + 1 + i);
        end
        if (res_cyc.size() > 0)
            chk("done_lat", done_cyc, res_cyc[res_cyc.size()-1] + 1);
        chk("idle_zero", idle_bad, 0);
        chk("q_err_none", err_n, 0);
    endtask

    task automatic run_op(input bit all, input logic [3:0] q,
                          input int gapmax);
        clear_mon();
        do_start(all, q);
        for (int k = 0; k < 16; k++) do_beat(k, gapmax);
        finish_check(all, q);
    endtask

    task automatic fill(input logic signed [31:0] re,
                        input logic signed [31:0] im, input bit diag);
        for (int k = 0; k < 16; k++) begin
            mr[k] = (!diag || (k / 4 == k % 4)) ? re : '0;
            mi[k] = (!diag || (k / 4 == k % 4)) ? im : '0;
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                mr[k] = $urandom;
                mi[k] = $urandom;
            end else begin
                mr[k] = $urandom_range(0, 1 << 19) - (1 << 18);
                mi[k] = $urandom_range(0, 1 << 19) - (1 << 18);
            end
        end
    endtask

    initial begin
        clear_mon();
        repeat (3) step();
        chk("rst_ready", H_in_ready, 0);
        chk("rst_valid", Dh_result_valid, 0);
        chk("rst_out", Dh_out, 0);
        chk("rst_done", q_calc_done, 0);
        chk("rst_err", q_err, 0);
        rst = 1'b0;
        step();

        fill(32'sh00010000, 0, 1'b1);
        run_op(1'b0, 4'd2, 0);
        chk("id_out", res_out.size() > 0 ? res_out[0] : 0, 32'h00010000);

        fill(32'sh00008000, 32'sh00008000, 1'b0);
        run_op(1'b1, 4'd0, 0);
        chk("half_out", res_out.size() > 3 ? res_out[3] : 0, 32'h00020000);

        fill(32'sh7FFFFFFF, 0, 1'b0);
        run_op(1'b1, 4'd0, 1);
        chk("big_sat", res_sat.size() > 0 ? res_sat[0] : 0, 1);

        clear_mon();
        do_start(1'b0, 4'd5);
        repeat (6) step();
        chk("bad_q_err", err_n, 1);
        chk("bad_q_ready", ready_n, 0);
        chk("bad_q_done", done_n, 0);

        fill_rand();
        do_start(1'b1, 4'd0);
        for (int k = 0; k < 7; k++) do_beat(k, 1);
        fill(32'sh00010000, 0, 1'b1);
        run_op(1'b0, 4'd1, 3);
        chk("restart_out", res_out.size() > 0 ? res_out[0] : 0,
            32'h00010000);

        fill_rand();
        do_start(1'b0, 4'd0);
        for (int k = 0; k < 7; k++) do_beat(k, 0);
        clear_mon();
        do_start(1'b0, 4'd9);
        repeat (5) step();
        chk("abort_err", err_n, 1);
        chk("abort_idle", H_in_ready, 0);

        clear_mon();
        fill_rand();
        do_start(1'b1, 4'd0);
        for (int k = 0; k < 10; k++) do_beat(k, 0);
        H_in_valid = 1'b1;
        H_in_r = mr[10];
        H_in_i = mi[10];
        rst = 1'b1;
        step();
        H_in_valid = 1'b0;
        rst = 1'b0;
        chk("rst_mid_rdy", H_in_ready, 0);
        chk("rst_mid_val", Dh_result_valid, 0);
        chk("rst_mid_out", Dh_out, 0);
        repeat (25) step();
        chk("rst_mid_res", res_col.size(), 0);
        chk("rst_mid_done", done_n, 0);

        fill_rand();
        run_op(1'b1, 4'd0, 2);

        for (int n = 0; n < 8; n++) begin
            fill_rand();
            run_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                   $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
